// File: rtl/stack_cpu_host_driver_pkg.sv
// Shared encodings for the stack CPU host driver: target modes, pin-bus bit map, FSM states.
// No logic of its own; pack_bus assembles the 8-bit target input bus from its fields.
// Imported by the driver top and its sub-blocks.
package stack_cpu_host_driver_pkg;

    typedef enum logic [2:0] {
        MODE_RUN   = 3'b000,
        MODE_ECHO  = 3'b001,
        MODE_HIST  = 3'b010,
        MODE_STACK = 3'b011,
        MODE_RST   = 3'b111
    } mode_t;

    localparam int TCLK_BIT  = 0;
    localparam int MODE2_BIT = 1;
    localparam int NIB_LSB   = 2;
    localparam int MODE_LSB  = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRESET = 2'd1,
        ST_RUN    = 2'd2,
        ST_READ   = 2'd3
    } state_t;

    // The target splits its mode field across the bus: bit 2 sits next to tclk, bits 1:0 on top.
    function automatic logic [7:0] pack_bus(input logic tclk, input logic [2:0] mode,
                                            input logic [3:0] nib);
        logic [7:0] b;
        b                 = '0;
        b[TCLK_BIT]       = tclk;
        b[MODE2_BIT]      = mode[2];
        b[NIB_LSB +: 4]   = nib;
        b[MODE_LSB +: 2]  = mode[1:0];
        return b;
    endfunction

endpackage

// File: rtl/stack_cpu_host_driver_if.sv
// Host-side and target-side signals of the stack CPU host driver.
// slave = driver view, master = harness/testbench view.
// No storage; pure signal bundle.
interface stack_cpu_host_driver_if;
    logic       start;
    logic [3:0] nib_data;
    logic       nib_valid;
    logic       nib_ready;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic [7:0] tgt_io_in;
    logic [7:0] tgt_io_out;

    modport slave (
        input  start, nib_data, nib_valid, rd_req, tgt_io_out,
        output nib_ready, rd_data, rd_valid, busy, tgt_io_in
    );

    modport master (
        output start, nib_data, nib_valid, rd_req, tgt_io_out,
        input  nib_ready, rd_data, rd_valid, busy, tgt_io_in
    );
endinterface

// File: rtl/stack_cpu_host_driver_nibble_fifo.sv
// Nibble FIFO feeding the target program stream; DEPTH must be a power of 2.
// Pop data is combinational from the head entry; push lands one cycle later.
// push_rdy from registered count: a same-cycle pop never frees a slot for that push.
module stack_cpu_host_driver_nibble_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push_vld,
    input  logic [3:0] push_dat,
    output logic       push_rdy,
    input  logic       pop_en,
    output logic [3:0] pop_dat,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign push_rdy = (count != (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld & push_rdy & ~flush;
    assign do_pop   = pop_en & ~empty & ~flush;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/stack_cpu_host_driver.sv
// Host driver for the stack CPU pins: target reset, one nibble per tclk, paused stack snapshots.
// Nibbles appear on the falling tclk edge; snapshot returns SETTLE (+2 with TGT_SYNC_EN) cycles after a fall.
// nib_ready drops when the FIFO is full; an empty FIFO streams NOPs rather than stalling tclk.
module stack_cpu_host_driver
    import stack_cpu_host_driver_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int RESET_CYCLES = 2,
    parameter int SETTLE       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_cpu_host_driver_if.slave bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES);
`ifdef TGT_SYNC_EN
    localparam int READ_LEN = SETTLE + 2;
`else
    localparam int READ_LEN = SETTLE;
`endif
    localparam int SC_W = $clog2(READ_LEN + 1);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(READ_LEN - 1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             tclk;
    mode_t            mode;
    logic [3:0]       nibble;
    logic             pending;
    logic [RC_W-1:0]  rst_cnt;
    logic [SC_W-1:0]  settle_cnt;
    logic [7:0]       rd_data_q;
    logic             rd_valid_q;
    logic [7:0]       cap_src;

    logic tick, rise_ev, fall_ev;
    logic restart, go_run, run_pop, enter_read, capture, clk_run, pop_en;
    logic fifo_empty;
    logic [3:0] fifo_dat;

    assign tick    = (div_cnt == DIV_LAST);
    assign rise_ev = tick & ~tclk;
    assign fall_ev = tick & tclk;
    assign pop_en  = go_run | run_pop;

`ifdef TGT_SYNC_EN
    logic [7:0] sync_q1, sync_q2;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= bus.tgt_io_out;
            sync_q2 <= sync_q1;
        end
    end
    assign cap_src = sync_q2;
`else
    assign cap_src = bus.tgt_io_out;
`endif

    stack_cpu_host_driver_nibble_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (restart),
        .push_vld (bus.nib_valid),
        .push_dat (bus.nib_data),
        .push_rdy (bus.nib_ready),
        .pop_en   (pop_en),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.start) begin
            state_nxt = ST_TRESET;
        end else begin
            case (state)
                ST_IDLE:   ;
                ST_TRESET: if (fall_ev && rst_cnt == RC_LAST) state_nxt = ST_RUN;
                ST_RUN:    if (fall_ev && pending) state_nxt = ST_READ;
                ST_READ:   if (settle_cnt == SETTLE_LAST) state_nxt = ST_RUN;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        restart    = bus.start;
        go_run     = 1'b0;
        run_pop    = 1'b0;
        enter_read = 1'b0;
        capture    = 1'b0;
        clk_run    = 1'b0;
        if (!bus.start) begin
            case (state)
                ST_TRESET: begin
                    clk_run = 1'b1;
                    go_run  = fall_ev && (rst_cnt == RC_LAST);
                end
                ST_RUN: begin
                    clk_run    = 1'b1;
                    enter_read = fall_ev & pending;
                    run_pop    = fall_ev & ~pending;
                end
                ST_READ: capture = (settle_cnt == SETTLE_LAST);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            tclk       <= 1'b0;
            mode       <= MODE_RST;
            nibble     <= '0;
            pending    <= 1'b0;
            rst_cnt    <= '0;
            settle_cnt <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= capture;
            if (capture) rd_data_q <= cap_src;

            // tclk is parked low whenever the target is not being clocked (IDLE, READ, restart).
            if (clk_run) begin
                if (tick) begin
                    div_cnt <= '0;
                    tclk    <= ~tclk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
                tclk    <= 1'b0;
            end

            // The serviced request is consumed on READ entry so a new rd_req during READ survives capture.
            if (restart && state != ST_IDLE) pending <= 1'b0;
            else if (enter_read)             pending <= bus.rd_req;
            else if (bus.rd_req)             pending <= 1'b1;

            if (restart) rst_cnt <= '0;
            else if (state == ST_TRESET && rise_ev && rst_cnt != RC_LAST) rst_cnt <= rst_cnt + 1'b1;

            if (enter_read)            settle_cnt <= '0;
            else if (state == ST_READ) settle_cnt <= settle_cnt + 1'b1;

            if (restart) begin
                mode   <= MODE_RST;
                nibble <= '0;
            end else if (go_run) begin
                mode   <= MODE_RUN;
                nibble <= fifo_empty ? 4'h0 : fifo_dat;
            end else if (run_pop) begin
                nibble <= fifo_empty ? 4'h0 : fifo_dat;
            end else if (enter_read) begin
                mode   <= MODE_STACK;
            end else if (capture) begin
                mode   <= MODE_RUN;
            end
        end
    end

    assign bus.tgt_io_in = pack_bus(tclk, mode, nibble);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
endmodule
